// File: rtl/mrf_pkg.sv
// Shared definitions for the matrix register file: default sizing,
// address typedefs and the read-port state encoding.
package mrf_pkg;

    // Default build configuration of the register file
    localparam int MRF_MESH_WIDTH = 4;
    localparam int MRF_DATA_WIDTH = 32;
    localparam int MRF_N_REGS     = 8;

    // Derived sizing: a register is N_ROWS rows of RLEN bits
    localparam int N_ROWS = MRF_MESH_WIDTH;
    localparam int RLEN   = MRF_DATA_WIDTH * MRF_MESH_WIDTH;
    localparam int REG_AW = $clog2(MRF_N_REGS);
    localparam int ROW_AW = $clog2(N_ROWS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [ROW_AW-1:0] row_addr_t;

    // Read port sequencing: wait for request, read array, present row
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mrf_read_port.sv
// One row-granular read port: captures a (register, row) request, reads the
// array one cycle later and presents the row until the requester takes it.
// A write hitting the captured row is forwarded so the port never returns a
// stale row.
module mrf_read_port
    import mrf_pkg::*;
#(
    parameter int RA_W  = 3,
    parameter int RR_W  = 2,
    parameter int ROW_W = 128
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [RA_W-1:0]  raddr_i,
    input  logic [RR_W-1:0]  rrowaddr_i,
    input  logic             rready_i,
    input  logic             raddr_locked_i,
    input  logic             wr_en_i,
    input  logic [RA_W-1:0]  wr_addr_i,
    input  logic [RR_W-1:0]  wr_rowaddr_i,
    input  logic [ROW_W-1:0] wr_data_i,
    input  logic [ROW_W-1:0] mem_row_i,
    output logic [RA_W-1:0]  cap_addr_o,
    output logic [RR_W-1:0]  cap_rowaddr_o,
    output logic [ROW_W-1:0] rdata_o,
    output logic             rdata_valid_o
);

    rd_state_t        state_reg;
    logic [RA_W-1:0]  cap_addr_reg;
    logic [RR_W-1:0]  cap_rowaddr_reg;
    logic [ROW_W-1:0] rdata_reg;
    logic             valid_reg;
    logic             wr_hit;

    // An accepted write this cycle lands on the row this port is working on
    assign wr_hit = wr_en_i && (wr_addr_i == cap_addr_reg) && (wr_rowaddr_i == cap_rowaddr_reg);

    // Read FSM with registered data/valid outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            cap_addr_reg    <= '0;
            cap_rowaddr_reg <= '0;
            rdata_reg       <= '0;
            valid_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (rready_i && !raddr_locked_i) begin
                        cap_addr_reg    <= raddr_i;
                        cap_rowaddr_reg <= rrowaddr_i;
                        state_reg       <= FETCH;
                    end
                end
                FETCH: begin
                    // Write-first: a same-cycle write to this row wins over the array
                    rdata_reg <= wr_hit ? wr_data_i : mem_row_i;
                    valid_reg <= 1'b1;
                    state_reg <= HOLD;
                end
                HOLD: begin
                    if (!rready_i) begin
                        // Requester walked away; discard the row
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else if (wr_hit) begin
                        // Row overwritten while presented: the handshake on the
                        // old value is void, present the new value instead
                        rdata_reg <= wr_data_i;
                    end else begin
                        // Row taken; chain straight into the next request if allowed
                        valid_reg <= 1'b0;
                        if (!raddr_locked_i) begin
                            cap_addr_reg    <= raddr_i;
                            cap_rowaddr_reg <= rrowaddr_i;
                            state_reg       <= FETCH;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cap_addr_o    = cap_addr_reg;
    assign cap_rowaddr_o = cap_rowaddr_reg;
    assign rdata_o       = rdata_reg;
    assign rdata_valid_o = valid_reg;

endmodule

// File: rtl/mrf_rowport_responder.sv
// Matrix register file with two row read ports (DATA, ACC) and one row write
// port. Registers under an unfinished write burst are locked against reads.
module mrf_rowport_responder
    import mrf_pkg::*;
#(
    parameter int MESH_WIDTH = MRF_MESH_WIDTH,
    parameter int DATA_WIDTH = MRF_DATA_WIDTH,
    parameter int N_REGS     = MRF_N_REGS,
    localparam int ROWS      = MESH_WIDTH,
    localparam int ROW_W     = DATA_WIDTH * MESH_WIDTH,
    localparam int RA_W      = $clog2(N_REGS),
    localparam int RR_W      = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [RA_W-1:0]  data_raddr_i,
    input  logic [RR_W-1:0]  data_rrowaddr_i,
    output logic [ROW_W-1:0] data_rdata_o,
    output logic             data_rdata_valid_o,
    input  logic             data_rdata_ready_i,
    input  logic             data_rlast_i,
    input  logic [RA_W-1:0]  acc_raddr_i,
    input  logic [RR_W-1:0]  acc_rrowaddr_i,
    output logic [ROW_W-1:0] acc_rdata_o,
    output logic             acc_rdata_valid_o,
    input  logic             acc_rdata_ready_i,
    input  logic             acc_rlast_i,
    input  logic [RA_W-1:0]  res_waddr_i,
    input  logic [RR_W-1:0]  res_wrowaddr_i,
    input  logic [ROW_W-1:0] res_wdata_i,
    input  logic             res_we_i,
    input  logic             res_wlast_i,
    output logic             res_wready_o
);

    logic [ROW_W-1:0]  mem_reg [N_REGS][ROWS];
    logic [N_REGS-1:0] lock_reg;
    logic [N_REGS-1:0] lock_next;
    logic              wready_reg;
    logic              wr_accept;

    logic [RA_W-1:0]   data_cap_addr, acc_cap_addr;
    logic [RR_W-1:0]   data_cap_row, acc_cap_row;
    logic [ROW_W-1:0]  data_mem_row, acc_mem_row;
    logic              data_locked, acc_locked;

    // Burst framing is carried by the handshake alone; rlast adds nothing
    logic unused_rlast;
    assign unused_rlast = data_rlast_i ^ acc_rlast_i;

    assign wr_accept    = res_we_i & wready_reg;
    assign res_wready_o = wready_reg;

    // Write port comes up ready one clock after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wready_reg <= 1'b0;
        end else begin
            wready_reg <= 1'b1;
        end
    end

    // Lock follows the write burst: set on a non-last row, cleared by wlast
    always_comb begin
        lock_next = lock_reg;
        if (wr_accept) begin
            lock_next[res_waddr_i] = ~res_wlast_i;
        end
    end

    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
            // Per-register lock bit
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lock_reg[gi] <= 1'b0;
                end else begin
                    lock_reg[gi] <= lock_next[gi];
                end
            end

            for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
                // Storage row, cleared by reset and written on an accepted write
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        mem_reg[gi][gj] <= '0;
                    end else if (wr_accept && (res_waddr_i == RA_W'(gi)) &&
                                 (res_wrowaddr_i == RR_W'(gj))) begin
                        mem_reg[gi][gj] <= res_wdata_i;
                    end
                end
            end
        end
    endgenerate

    // Gate requests on the lock as it will be after this edge, so a read waiting
    // on a burst issues its fetch right after the wlast row lands
    assign data_locked  = lock_next[data_raddr_i];
    assign acc_locked   = lock_next[acc_raddr_i];
    assign data_mem_row = mem_reg[data_cap_addr][data_cap_row];
    assign acc_mem_row  = mem_reg[acc_cap_addr][acc_cap_row];

    mrf_read_port #(
        .RA_W  (RA_W),
        .RR_W  (RR_W),
        .ROW_W (ROW_W)
    ) u_data_port (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .raddr_i        (data_raddr_i),
        .rrowaddr_i     (data_rrowaddr_i),
        .rready_i       (data_rdata_ready_i),
        .raddr_locked_i (data_locked),
        .wr_en_i        (wr_accept),
        .wr_addr_i      (res_waddr_i),
        .wr_rowaddr_i   (res_wrowaddr_i),
        .wr_data_i      (res_wdata_i),
        .mem_row_i      (data_mem_row),
        .cap_addr_o     (data_cap_addr),
        .cap_rowaddr_o  (data_cap_row),
        .rdata_o        (data_rdata_o),
        .rdata_valid_o  (data_rdata_valid_o)
    );

    mrf_read_port #(
        .RA_W  (RA_W),
        .RR_W  (RR_W),
        .ROW_W (ROW_W)
    ) u_acc_port (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .raddr_i        (acc_raddr_i),
        .rrowaddr_i     (acc_rrowaddr_i),
        .rready_i       (acc_rdata_ready_i),
        .raddr_locked_i (acc_locked),
        .wr_en_i        (wr_accept),
        .wr_addr_i      (res_waddr_i),
        .wr_rowaddr_i   (res_wrowaddr_i),
        .wr_data_i      (res_wdata_i),
        .mem_row_i      (acc_mem_row),
        .cap_addr_o     (acc_cap_addr),
        .cap_rowaddr_o  (acc_cap_row),
        .rdata_o        (acc_rdata_o),
        .rdata_valid_o  (acc_rdata_valid_o)
    );

endmodule

// File: doc/mrf_rowport_responder.md
Name: mrf_rowport_responder

Overview:
- Matrix register file (MRF) with its row-granular port responder: the target side of the systolic-array read and write-back ports.
- Serves two dedicated read ports (DATA and ACC) and one result write port. Each read port is a valid/ready row stream with a fixed 1-cycle array-read latency. The write port accepts one row per cycle on we&wready.
- Per-register write locks hold off reads of any register whose write-back burst has started but not reached wlast.

Parameters:
MESH_WIDTH, 4, rows per register and elements per row
DATA_WIDTH, 32, element width in bits
N_REGS, 8, number of matrix registers
N_ROWS (local), MESH_WIDTH, rows per register
RLEN (local), DATA_WIDTH*MESH_WIDTH, row width in bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_raddr_i  in  $clog2(N_REGS)  DATA port register address
data_rrowaddr_i  in  $clog2(N_ROWS)  DATA port row address
data_rdata_o  out  RLEN  DATA row
data_rdata_valid_o  out  1  DATA row valid
data_rdata_ready_i  in  1  requester ready; high = read request active
data_rlast_i  in  1  last row of burst (informational; sampled only with handshake)
acc_raddr_i, acc_rrowaddr_i, acc_rdata_o, acc_rdata_valid_o, acc_rdata_ready_i, acc_rlast_i  (same widths and meanings, ACC port)
res_waddr_i  in  $clog2(N_REGS)  write register
res_wrowaddr_i  in  $clog2(N_ROWS)  write row
res_wdata_i  in  RLEN  write row data
res_we_i  in  1  write request
res_wlast_i  in  1  last row of write burst
res_wready_o  out  1  write accepted when high with res_we_i

Behaviour:
- Reset (asynchronous, active-low), applied at any time including mid-burst:
  - All storage rows are cleared to 0, all locks are cleared, and both read FSMs return to IDLE.
  - Outputs: rdata_valid_o=0, rdata_o=0, res_wready_o=0.
  - res_wready_o rises to 1 on the first clock after reset release.
- Write port:
  - res_wready_o=1 whenever out of reset.
  - Accept = res_we_i & res_wready_o. On accept, the row is written at the clock edge.
  - Lock: lock[waddr] is set on any accept without wlast. lock[waddr] is cleared on accept with wlast; a single-row burst with wlast leaves no lock.
  - Simultaneous set and clear of the same register cannot occur: one write per cycle.
- Read port FSM (identical per port), states IDLE, FETCH, HOLD:
  - IDLE -> FETCH when ready_i=1 and lock[raddr]=0. The captured address is (raddr, rrowaddr).
  - FETCH: the array row is registered into rdata_o. Go to HOLD with valid_o=1 the next cycle, giving latency 2 cycles from request to valid.
  - HOLD, valid&ready: valid_o drops next cycle. If ready_i is still high and the new address is unlocked, re-enter FETCH the same edge, giving throughput 1 row per 2 cycles. Otherwise go to IDLE.
  - HOLD, ready_i=0: the requester has abandoned. Drop valid next cycle and go to IDLE; the data is discarded.
  - HOLD, presented address differs from captured address: drop valid and re-FETCH.
  - Write hazard: a write accepted to the captured reg/row while in FETCH or HOLD must be reflected. Rule: write-first bypass in FETCH. In HOLD, rdata_o is updated with res_wdata_i the next cycle and valid stays high.
- Locked register: no FETCH is issued and valid stays 0 until the lock clears. The first FETCH occurs on the cycle after the wlast accept.
- Both read ports may target the same register or row concurrently; there is no arbitration.
- rlast_i has no effect on state beyond the normal handshake.
- The design has no deadlock source internal to the block. The requester must not wait on reads of a register it is itself writing.

Decomposition:
- Shared package mrf_pkg: sizing localparams (N_ROWS, RLEN), the read FSM state enum (IDLE/FETCH/HOLD), and the address typedefs reg_addr_t and row_addr_t.
- Sub-module mrf_read_port: one read FSM with its capture register and bypass logic. Instantiated twice.
- The storage array and lock vector stay in the top.

Test Plan:
- Reset, then write reg 2 rows 0..3 with values 0x10..0x13 and wlast on row 3 -> wready=1 throughout; lock[2] is high for cycles 1-3 and low after the wlast edge.
- DATA port requests reg 2 rows 0..3 with ready held high -> valid on cycles t+2, t+4, t+6, t+8; data 0x10..0x13. ACC port reads reg 5 concurrently with the same timing.
- ACC port requests reg 3 while a write burst to reg 3 is at row 1 -> valid stays 0 until the cycle after the wlast accept; the first row returned equals the newly written data.
- HOLD on reg 1 row 0, then write 0xAB to reg 1 row 0 without wlast -> rdata_o becomes 0xAB the next cycle and valid remains 1.
- Requester drops ready during HOLD -> valid is 0 the next cycle and the FSM is IDLE; a subsequent request returns fresh data.
- Assert rst_ni low mid-read and mid-write burst -> valids=0, wready=0, all locks clear, and a read of any register returns 0 after release.
